// File: rtl/csu_ctrl_pkg.sv
// csu_ctrl_pkg: shared state encoding, code limits and testbus select encoding for the current-source controller.
package csu_ctrl_pkg;
    typedef enum logic [1:0] {OFF, POWERUP, IDLE, RAMP} csu_state_e;
    localparam int CODE_MAX = 1151;
    localparam int LSB_PER_THERM = 64;
    localparam logic [1:0] ATB_Z = 2'b00;
    localparam logic [1:0] ATB_SUPPLY = 2'b01;
    localparam logic [1:0] ATB_VDDANA_THERM16 = 2'b10;
    localparam logic [1:0] ATB_IREF_RED = 2'b11;
endpackage

// File: rtl/csu_therm_decoder.sv
// csu_therm_decoder: maps a unit count to a thermometer vector, bit i set when i < count.
module csu_therm_decoder #(
    parameter int N_THERM = 17,
    parameter int CNT_W   = 5
) (
    input  logic [CNT_W-1:0]   count,
    output logic [N_THERM-1:0] therm
);
    for (genvar i = 0; i < N_THERM; i++) begin : g_th
        assign therm[i] = count > CNT_W'(i);
    end
endmodule

// File: rtl/csu_segment_ctrl.sv
// csu_segment_ctrl: power-up sequencing, one-unit thermometer ramp and binary/LSB enables for the segmented current-source unit.
// Build macro CSU_LSB_ROTATE_EN alternates the LSB between bin_en_o[0] and bin_red_en_o; undefined ties bin_red_en_o low.
module csu_segment_ctrl
    import csu_ctrl_pkg::*;
#(
    parameter int N_THERM    = 17,
    parameter int N_BIN      = 6,
    parameter int CODE_W     = 11,
    parameter int SETTLE_CYC = 16,
    parameter int STEP_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [CODE_W-1:0] code_i,
    input  logic              code_valid_i,
    output logic              code_ready_o,
    input  logic [1:0]        atb_sel_i,
    output logic              pdb_o,
    output logic [N_THERM-1:0] therm_en_o,
    output logic [N_BIN-1:0]  bin_en_o,
    output logic              bin_red_en_o,
    output logic [1:0]        atb_ena_o,
    output logic              settled_o,
    output logic              code_err_o
);
    localparam int TW = CODE_W - N_BIN;
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int PW = $clog2(STEP_CYC + 1);

    csu_state_e       state;
    logic [TW-1:0]    count, tgt_therm, tgt_therm_q, nxt;
    logic [N_BIN-1:0] tgt_bin, tgt_bin_q, acc_bin, ramp_bin;
    logic             over, accept, acc_red, ramp_red;
    logic [SW-1:0]    set_cnt;
    logic [PW-1:0]    step_cnt;
    logic [1:0]       atb_q;

    // target split with saturation of out-of-range codes, and the next ramp count
    always_comb begin
        over      = code_i > CODE_W'(CODE_MAX);
        tgt_therm = over ? TW'(N_THERM) : code_i[CODE_W-1:N_BIN];
        tgt_bin   = over ? '1 : code_i[N_BIN-1:0];
        accept    = enable_i && code_valid_i && code_ready_o;
        nxt       = (tgt_therm_q > count) ? count + TW'(1) : count - TW'(1);
    end

`ifdef CSU_LSB_ROTATE_EN
    logic tog, sel_q;
    // toggle advances on each accepted odd code; the pre-flip value picks the LSB source for that code
    always_ff @(posedge clk) begin
        if (rst) begin
            tog   <= 1'b0;
            sel_q <= 1'b0;
        end else if (accept) begin
            sel_q <= tog;
            tog   <= tog ^ tgt_bin[0];
        end
    end
    assign acc_bin  = {tgt_bin[N_BIN-1:1], tgt_bin[0] & ~tog};
    assign acc_red  = tgt_bin[0] & tog;
    assign ramp_bin = {tgt_bin_q[N_BIN-1:1], tgt_bin_q[0] & ~sel_q};
    assign ramp_red = tgt_bin_q[0] & sel_q;
`else
    assign acc_bin  = tgt_bin;
    assign acc_red  = 1'b0;
    assign ramp_bin = tgt_bin_q;
    assign ramp_red = 1'b0;
`endif

    csu_therm_decoder #(.N_THERM(N_THERM), .CNT_W(TW)) u_dec (
        .count(count),
        .therm(therm_en_o)
    );

    assign atb_ena_o = pdb_o ? atb_q : ATB_Z;

    // sequencing FSM: enable drop from any state abandons work and powers down
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= OFF;
            pdb_o        <= 1'b0;
            count        <= '0;
            bin_en_o     <= '0;
            bin_red_en_o <= 1'b0;
            code_ready_o <= 1'b0;
            settled_o    <= 1'b0;
            code_err_o   <= 1'b0;
            set_cnt      <= '0;
            step_cnt     <= '0;
            tgt_therm_q  <= '0;
            tgt_bin_q    <= '0;
            atb_q        <= ATB_Z;
        end else begin
            atb_q <= atb_sel_i;
            if (!enable_i) begin
                state        <= OFF;
                pdb_o        <= 1'b0;
                count        <= '0;
                bin_en_o     <= '0;
                bin_red_en_o <= 1'b0;
                code_ready_o <= 1'b0;
                settled_o    <= 1'b0;
            end else begin
                case (state)
                    OFF: begin
                        state   <= POWERUP;
                        pdb_o   <= 1'b1;
                        set_cnt <= '0;
                    end
                    POWERUP: begin
                        if (set_cnt == SW'(SETTLE_CYC - 1)) begin
                            state        <= IDLE;
                            code_ready_o <= 1'b1;
                        end else begin
                            set_cnt <= set_cnt + SW'(1);
                        end
                    end
                    IDLE: begin
                        if (accept) begin
                            tgt_therm_q <= tgt_therm;
                            tgt_bin_q   <= tgt_bin;
                            step_cnt    <= '0;
                            code_err_o  <= code_err_o | over;
                            if (tgt_therm == count) begin
                                bin_en_o     <= acc_bin;
                                bin_red_en_o <= acc_red;
                                settled_o    <= 1'b1;
                            end else begin
                                state        <= RAMP;
                                code_ready_o <= 1'b0;
                                settled_o    <= 1'b0;
                            end
                        end
                    end
                    RAMP: begin
                        if (step_cnt == PW'(STEP_CYC - 1)) begin
                            step_cnt <= '0;
                            count    <= nxt;
                            if (nxt == tgt_therm_q) begin
                                bin_en_o     <= ramp_bin;
                                bin_red_en_o <= ramp_red;
                                state        <= IDLE;
                                code_ready_o <= 1'b1;
                                settled_o    <= 1'b1;
                            end
                        end else begin
                            step_cnt <= step_cnt + PW'(1);
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_csu_segment_ctrl.sv
// tb_csu_segment_ctrl: scoreboard bench for csu_segment_ctrl; honours CSU_LSB_ROTATE_EN in its reference model.
module tb_csu_segment_ctrl;
    logic        clk = 1'b0, rst = 1'b1, enable_i = 1'b0, code_valid_i = 1'b0;
    logic [10:0] code_i = '0;
    logic [1:0]  atb_sel_i = 2'b00;
    logic        code_ready_o, pdb_o, bin_red_en_o, settled_o, code_err_o;
    logic [16:0] therm_en_o;
    logic [5:0]  bin_en_o;
    logic [1:0]  atb_ena_o;

    typedef struct {
        logic [16:0] therm;
        logic [5:0]  bin;
        logic        red;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0, fails = 0, m_cnt = 0;
    logic m_tog = 1'b0, m_err = 1'b0;

    csu_segment_ctrl dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .code_i(code_i),
        .code_valid_i(code_valid_i), .code_ready_o(code_ready_o), .atb_sel_i(atb_sel_i),
        .pdb_o(pdb_o), .therm_en_o(therm_en_o), .bin_en_o(bin_en_o),
        .bin_red_en_o(bin_red_en_o), .atb_ena_o(atb_ena_o), .settled_o(settled_o),
        .code_err_o(code_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_code(input int code);
        exp_t e;
        int   t, b;
        logic ovr;
        ovr     = code > 1151;
        t       = ovr ? 17 : code / 64;
        b       = ovr ? 63 : code % 64;
        m_err   = m_err | ovr;
        e.therm = 17'((1 << t) - 1);
        e.bin   = 6'(b);
        e.red   = 1'b0;
`ifdef CSU_LSB_ROTATE_EN
        if (b % 2 == 1) begin
            e.bin[0] = !m_tog;
            e.red    = m_tog;
            m_tog    = !m_tog;
        end
`endif
        e.err = m_err;
        e.lat = t > m_cnt ? t - m_cnt : m_cnt - t;
        m_cnt = t;
        sb.push_back(e);
    endtask

    task automatic issue_code(input int code);
        int n = 0;
        code_i = 11'(code);
        code_valid_i = 1'b1;
        while (!code_ready_o && n < 200) begin
            tick;
            n++;
        end
        tests++;
        if (code_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL issue_ready code=%0d: ready=%b required 1", code, code_ready_o);
        end
        tick;
        code_valid_i = 1'b0;
        expect_code(code);
    endtask

    task automatic collect(input int elapsed);
        exp_t e;
        int   n = elapsed;
        while (!settled_o && n < 200) begin
            tick;
            n++;
        end
        e = sb.pop_front();
        tests += 6;
        if (n !== e.lat) begin
            fails++;
            $display("FAIL latency: got %0d cycles required %0d", n, e.lat);
        end
        if (therm_en_o !== e.therm) begin
            fails++;
            $display("FAIL therm: got %05h required %05h", therm_en_o, e.therm);
        end
        if (bin_en_o !== e.bin) begin
            fails++;
            $display("FAIL bin: got %02h required %02h", bin_en_o, e.bin);
        end
        if (bin_red_en_o !== e.red) begin
            fails++;
            $display("FAIL red: got %b required %b", bin_red_en_o, e.red);
        end
        if (code_err_o !== e.err) begin
            fails++;
            $display("FAIL code_err: got %b required %b", code_err_o, e.err);
        end
        if (bin_en_o[0] && bin_red_en_o) begin
            fails++;
            $display("FAIL lsb_exclusive: bin0=%b red=%b required not both", bin_en_o[0], bin_red_en_o);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        tests++;
        if ({pdb_o, therm_en_o, bin_en_o, bin_red_en_o, atb_ena_o, code_ready_o, settled_o, code_err_o} !== '0) begin
            fails++;
            $display("FAIL reset_values: pdb=%b therm=%05h bin=%02h red=%b atb=%b rdy=%b set=%b err=%b required all 0",
                     pdb_o, therm_en_o, bin_en_o, bin_red_en_o, atb_ena_o, code_ready_o, settled_o, code_err_o);
        end
        rst = 1'b0;
        tick;
        tests++;
        if (pdb_o !== 1'b0) begin
            fails++;
            $display("FAIL off_hold: pdb=%b required 0", pdb_o);
        end
    endtask

    task automatic test_powerup;
        enable_i = 1'b1;
        tick;
        tests++;
        if (pdb_o !== 1'b1 || code_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL pdb_rise: pdb=%b rdy=%b required 1 0", pdb_o, code_ready_o);
        end
        for (int k = 1; k <= 16; k++) begin
            tick;
            tests += 2;
            if (code_ready_o !== 1'(k == 16)) begin
                fails++;
                $display("FAIL settle_ready cycle %0d: got %b required %b", k, code_ready_o, k == 16);
            end
            if (therm_en_o !== '0 || bin_en_o !== '0 || bin_red_en_o !== 1'b0) begin
                fails++;
                $display("FAIL powerup_enables cycle %0d: therm=%05h bin=%02h red=%b required 0", k, therm_en_o, bin_en_o, bin_red_en_o);
            end
        end
        tests++;
        if (settled_o !== 1'b0) begin
            fails++;
            $display("FAIL first_idle_settled: got %b required 0", settled_o);
        end
    endtask

    task automatic test_ramp_up;
        issue_code(130);
        tests++;
        if (therm_en_o !== '0 || code_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL ramp_start: therm=%05h rdy=%b required 0 0", therm_en_o, code_ready_o);
        end
        tick;
        tests++;
        if (therm_en_o !== 17'h00001 || bin_en_o !== 6'b0) begin
            fails++;
            $display("FAIL ramp_step1: therm=%05h bin=%02h required 00001 00", therm_en_o, bin_en_o);
        end
        tick;
        tests++;
        if (therm_en_o !== 17'h00003 || bin_en_o !== 6'b000010) begin
            fails++;
            $display("FAIL ramp_step2: therm=%05h bin=%02h required 00003 02", therm_en_o, bin_en_o);
        end
        collect(2);
    endtask

    task automatic test_saturate;
        issue_code(1200);
        collect(0);
        issue_code(5);
        collect(0);
    endtask

    task automatic test_hold;
        issue_code(640);
        code_i = 11'd70;
        code_valid_i = 1'b1;
        tests++;
        if (code_ready_o !== 1'b0) begin
            fails++;
            $display("FAIL hold_ready: got %b required 0", code_ready_o);
        end
        collect(0);
        tick;
        code_valid_i = 1'b0;
        expect_code(70);
        collect(0);
    endtask

    task automatic test_abort;
        issue_code(1088);
        collect(0);
        issue_code(64);
        for (int k = 0; k < 7; k++) tick;
        tests++;
        if (therm_en_o !== 17'h003FF) begin
            fails++;
            $display("FAIL ramp_down_step7: therm=%05h required 003ff", therm_en_o);
        end
        enable_i = 1'b0;
        tick;
        tests++;
        if ({pdb_o, therm_en_o, bin_en_o, bin_red_en_o, code_ready_o, settled_o} !== '0) begin
            fails++;
            $display("FAIL abort: pdb=%b therm=%05h bin=%02h red=%b rdy=%b set=%b required all 0",
                     pdb_o, therm_en_o, bin_en_o, bin_red_en_o, code_ready_o, settled_o);
        end
        void'(sb.pop_front());
        m_cnt = 0;
        test_powerup;
    endtask

    task automatic test_atb;
        atb_sel_i = 2'b10;
        tick;
        tests++;
        if (atb_ena_o !== 2'b10) begin
            fails++;
            $display("FAIL atb_10: got %b required 10", atb_ena_o);
        end
        atb_sel_i = 2'b11;
        tick;
        tests++;
        if (atb_ena_o !== 2'b11) begin
            fails++;
            $display("FAIL atb_11: got %b required 11", atb_ena_o);
        end
        enable_i = 1'b0;
        tick;
        tests++;
        if (atb_ena_o !== 2'b00) begin
            fails++;
            $display("FAIL atb_off: got %b required 00", atb_ena_o);
        end
        tick;
        tests++;
        if (atb_ena_o !== 2'b00) begin
            fails++;
            $display("FAIL atb_off_hold: got %b required 00", atb_ena_o);
        end
        atb_sel_i = 2'b00;
        m_cnt = 0;
        test_powerup;
    endtask

    task automatic test_rotate;
        issue_code(1);
        collect(0);
        issue_code(3);
        collect(0);
        issue_code(1);
        collect(0);
    endtask

    task automatic test_reset_mid_ramp;
        issue_code(1151);
        tick;
        tick;
        tick;
        enable_i = 1'b0;
        rst = 1'b1;
        tick;
        tests++;
        if ({pdb_o, therm_en_o, bin_en_o, bin_red_en_o, atb_ena_o, code_ready_o, settled_o, code_err_o} !== '0) begin
            fails++;
            $display("FAIL reset_mid_ramp: pdb=%b therm=%05h bin=%02h red=%b atb=%b rdy=%b set=%b err=%b required all 0",
                     pdb_o, therm_en_o, bin_en_o, bin_red_en_o, atb_ena_o, code_ready_o, settled_o, code_err_o);
        end
        rst = 1'b0;
        void'(sb.pop_front());
        m_cnt = 0;
        m_tog = 1'b0;
        m_err = 1'b0;
    endtask

    initial begin
        test_reset;
        test_powerup;
        test_ramp_up;
        test_saturate;
        test_hold;
        test_abort;
        test_atb;
        test_rotate;
        test_reset_mid_ramp;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
